mig_port_arbiter: RTL
=====================

Name: mig_port_arbiter

Overview:
- Shares the single DDR2 MIG user interface (address/command FIFO and write-data FIFO) between one write client (the 768-bit write burst engine) and one read client (the burst reader).
- Grants one client at a time and muxes that client's app_af_*/app_wdf_* strobes to the MIG.
- Tracks outstanding read bursts so a write grant never starts while read data is still returning.
- Sits between the client engines and the MIG user interface in the memory subsystem.

Parameters:
- BEATS_PER_CMD, 2, rd_data_valid beats returned per read command (128-bit beats).
- TURN_CYCLES, 4, idle cycles inserted after a write grant releases, before the next grant.
- MAX_OUTSTANDING, 15, read commands in flight; 4-bit counter; read client is throttled when this is reached.
- TIMEOUT, 1023, cycles a grant may be held before timeout_err is raised.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- phy_init_done  in  1  MIG calibration done; no grant is issued while low
- wr_req  in  1  write client request; held high for the whole transaction
- rd_req  in  1  read client request; held high for the whole transaction
- wr_gnt  out  1  write client granted
- rd_gnt  out  1  read client granted
- wr_af_wren, wr_af_cmd[2:0], wr_af_addr[31:0], wr_wdf_wren, wr_wdf_data[127:0]  in  -  write client MIG-side signals
- rd_af_wren, rd_af_cmd[2:0], rd_af_addr[31:0]  in  -  read client MIG-side signals
- app_af_afull, app_wdf_afull  in  1  MIG almost-full flags; passed through to clients
- rd_data_valid  in  1  MIG read data beat strobe
- app_af_wren  out  1  muxed address FIFO write enable
- app_af_cmd  out  3  muxed command
- app_af_addr  out  32  muxed address
- app_wdf_wren  out  1  muxed write-data FIFO enable
- app_wdf_data  out  128  muxed write data
- rd_throttle  out  1  read client must not issue a further command
- rd_outstanding  out  4  read commands still awaiting data
- timeout_err  out  1  sticky; grant held longer than TIMEOUT

Behaviour:
- Reset values: every output 0; FSM in IDLE; all counters 0; the last-served pointer points at the reader, so the writer wins the first tie.
- FSM states:
  - IDLE:
    - Requires phy_init_done=1.
    - Only wr_req set -> GNT_WR.
    - Only rd_req set -> GNT_RD.
    - Both set -> grant the client not served last (round robin).
    - Grant outputs are registered: the grant appears 1 cycle after a request is sampled in IDLE.
  - GNT_WR: wr_gnt=1. When wr_req falls -> TURN. wr_gnt deasserts in the same cycle TURN is entered.
  - TURN: count TURN_CYCLES idle cycles, then -> IDLE.
  - GNT_RD: rd_gnt=1. When rd_req falls -> DRAIN.
  - DRAIN:
    - Stay until rd_outstanding==0, then -> IDLE.
    - A pending rd_req may re-grant directly to GNT_RD only if wr_req=0.
- Muxing: combinational from registered grants.
  - app_* outputs follow the granted client's inputs.
  - All enables are 0 when no client is granted.
  - app_wdf_* is always 0 while the read client is granted.
  - Enables from a non-granted client are ignored, with no side effects.
- Read tracking:
  - rd_outstanding increments on each muxed app_af_wren with cmd=3'b001.
  - A beat counter counts rd_data_valid; every BEATS_PER_CMD beats it decrements rd_outstanding.
  - A command issue and a burst completion in the same cycle leave the count unchanged.
  - No wrap: rd_throttle = (rd_outstanding==MAX_OUTSTANDING) | app_af_afull.
  - A command issued while rd_outstanding==MAX_OUTSTANDING saturates the counter and sets timeout_err, which doubles as the protocol error flag.
- Timeout:
  - The hold counter resets on every grant change.
  - When it reaches TIMEOUT in GNT_WR or GNT_RD, timeout_err sets and stays set until reset.
  - The grant is not revoked.
- phy_init_done falling mid-grant: the current grant continues; no new grant is issued until it rises again.
- Reset mid-transaction: grants drop the next edge and counters clear. In-flight read data after reset is ignored; the beat counter holds at 0 and does not underflow.

Optional Feature:
- MIG_ARB_STATS_EN defined:
  - Adds outputs wr_grant_cnt[15:0] and rd_grant_cnt[15:0] (grants issued per client) and stall_cnt[15:0] (cycles a request waited in IDLE/TURN/DRAIN).
  - All saturating, cleared by reset.
- Undefined: these ports and their counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, phy_init_done=0, wr_req=1 -> no grant. Raise phy_init_done -> wr_gnt=1 two cycles later. Client writes 8 wdf beats -> app_wdf_wren pulses 8 times with matching data.
- wr_req and rd_req both high from IDLE -> wr_gnt first. After wr_req falls, 4 idle cycles, then rd_gnt. Next tie -> wr_gnt (alternation).
- Read client issues 3 commands then drops rd_req, wr_req=1 -> DRAIN holds. After 6 rd_data_valid beats rd_outstanding=0, then wr_gnt.
- Read client issues 15 commands with no data returning -> rd_throttle=1 and rd_outstanding=15. Two beats arrive -> 14, rd_throttle=0. Issue and completion in the same cycle -> count unchanged.
- Write client holds wr_req for 1100 cycles -> timeout_err=1 at hold cycle 1023, stays 1 after the release; wr_gnt is not forced low.
- Reset asserted mid-GNT_RD with 2 outstanding -> next cycle grants=0, rd_outstanding=0. Stray rd_data_valid beats -> no underflow.

Source files
------------

// File: rtl/mig_port_arbiter_if.sv
// Client/MIG user-interface bundle for mig_port_arbiter.
// Optional counters are present only when MIG_ARB_STATS_EN is defined.
interface mig_port_arbiter_if;
  logic         phy_init_done;
  logic         wr_req, rd_req;
  logic         wr_gnt, rd_gnt;
  logic         wr_af_wren;
  logic [2:0]   wr_af_cmd;
  logic [31:0]  wr_af_addr;
  logic         wr_wdf_wren;
  logic [127:0] wr_wdf_data;
  logic         rd_af_wren;
  logic [2:0]   rd_af_cmd;
  logic [31:0]  rd_af_addr;
  logic         app_af_afull, app_wdf_afull;
  logic         rd_data_valid;
  logic         app_af_wren;
  logic [2:0]   app_af_cmd;
  logic [31:0]  app_af_addr;
  logic         app_wdf_wren;
  logic [127:0] app_wdf_data;
  logic         rd_throttle;
  logic [3:0]   rd_outstanding;
  logic         timeout_err;
`ifdef MIG_ARB_STATS_EN
  logic [15:0]  wr_grant_cnt, rd_grant_cnt, stall_cnt;
`endif

  // app_wdf_afull is not consumed by the arbiter; the write client reads it here directly.
  modport slave (
    input  phy_init_done, wr_req, rd_req,
    input  wr_af_wren, wr_af_cmd, wr_af_addr, wr_wdf_wren, wr_wdf_data,
    input  rd_af_wren, rd_af_cmd, rd_af_addr,
    input  app_af_afull, rd_data_valid,
    output wr_gnt, rd_gnt,
    output app_af_wren, app_af_cmd, app_af_addr, app_wdf_wren, app_wdf_data,
    output rd_throttle, rd_outstanding, timeout_err
`ifdef MIG_ARB_STATS_EN
    , output wr_grant_cnt, rd_grant_cnt, stall_cnt
`endif
  );

  modport master (
    output phy_init_done, wr_req, rd_req,
    output wr_af_wren, wr_af_cmd, wr_af_addr, wr_wdf_wren, wr_wdf_data,
    output rd_af_wren, rd_af_cmd, rd_af_addr,
    output app_af_afull, app_wdf_afull, rd_data_valid,
    input  wr_gnt, rd_gnt,
    input  app_af_wren, app_af_cmd, app_af_addr, app_wdf_wren, app_wdf_data,
    input  rd_throttle, rd_outstanding, timeout_err
`ifdef MIG_ARB_STATS_EN
    , input wr_grant_cnt, rd_grant_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/mig_port_arbiter.sv
// Round-robin arbiter sharing one DDR2 MIG user interface between a write and a read client.
// Define MIG_ARB_STATS_EN to add saturating grant/stall counters.
module mig_port_arbiter #(
  parameter int BEATS_PER_CMD   = 2,
  parameter int TURN_CYCLES     = 4,
  parameter int MAX_OUTSTANDING = 15,
  parameter int TIMEOUT         = 1023
) (
  input logic               clk,
  input logic               reset,
  mig_port_arbiter_if.slave bus
);
  localparam int BEAT_W = (BEATS_PER_CMD > 1) ? $clog2(BEATS_PER_CMD) : 1;
  localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int HOLD_W = $clog2(TIMEOUT + 1);
  localparam logic [2:0] CMD_READ = 3'b001;

  typedef enum logic [2:0] {IDLE, GNT_WR, TURN, GNT_RD, DRAIN} state_t;

  typedef struct packed {
    logic        wren;
    logic [2:0]  cmd;
    logic [31:0] addr;
  } af_req_t;

  state_t              state;
  logic                wr_gnt_q, rd_gnt_q, last_rd;
  logic [TURN_W-1:0]   turn_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [3:0]          outstanding;
  logic                err_q;

  af_req_t wr_af, rd_af, mux_af;
  logic    pick_wr, pick_rd, regrant_rd, grant_hold, hold_hit;
  logic    rd_issue, beat_en, burst_done, at_max;

  assign wr_af = '{wren: bus.wr_af_wren, cmd: bus.wr_af_cmd, addr: bus.wr_af_addr};
  assign rd_af = '{wren: bus.rd_af_wren, cmd: bus.rd_af_cmd, addr: bus.rd_af_addr};

  // Grants are registered, so the mux never sees a same-cycle request decision.
  always_comb begin
    mux_af = '0;
    if (wr_gnt_q)      mux_af = wr_af;
    else if (rd_gnt_q) mux_af = rd_af;
  end

  assign bus.app_af_wren  = mux_af.wren;
  assign bus.app_af_cmd   = mux_af.cmd;
  assign bus.app_af_addr  = mux_af.addr;
  assign bus.app_wdf_wren = wr_gnt_q & bus.wr_wdf_wren;
  assign bus.app_wdf_data = wr_gnt_q ? bus.wr_wdf_data : '0;
  assign bus.wr_gnt       = wr_gnt_q;
  assign bus.rd_gnt       = rd_gnt_q;

  // Tie-break: the writer wins unless it was the last one served.
  assign pick_wr    = (state == IDLE) && bus.phy_init_done && bus.wr_req &&
                      (!bus.rd_req || last_rd);
  assign pick_rd    = (state == IDLE) && bus.phy_init_done && bus.rd_req &&
                      !(bus.wr_req && last_rd);
  assign regrant_rd = (state == DRAIN) && bus.phy_init_done && bus.rd_req && !bus.wr_req;
  assign grant_hold = ((state == GNT_WR) && bus.wr_req) || ((state == GNT_RD) && bus.rd_req);
  assign hold_hit   = grant_hold && (hold_cnt == HOLD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_gnt_q <= 1'b0;
      rd_gnt_q <= 1'b0;
      last_rd  <= 1'b1;
      turn_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      if (!grant_hold)                          hold_cnt <= '0;
      else if (hold_cnt != HOLD_W'(TIMEOUT))    hold_cnt <= hold_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (pick_wr) begin
            state    <= GNT_WR;
            wr_gnt_q <= 1'b1;
            last_rd  <= 1'b0;
          end else if (pick_rd) begin
            state    <= GNT_RD;
            rd_gnt_q <= 1'b1;
            last_rd  <= 1'b1;
          end
        end
        GNT_WR: begin
          if (!bus.wr_req) begin
            state    <= TURN;
            wr_gnt_q <= 1'b0;
            turn_cnt <= '0;
          end
        end
        TURN: begin
          if (turn_cnt == TURN_W'(TURN_CYCLES - 1)) state <= IDLE;
          else                                       turn_cnt <= turn_cnt + 1'b1;
        end
        GNT_RD: begin
          if (!bus.rd_req) begin
            state    <= DRAIN;
            rd_gnt_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (regrant_rd) begin
            state    <= GNT_RD;
            rd_gnt_q <= 1'b1;
            last_rd  <= 1'b1;
          end else if (outstanding == '0) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          wr_gnt_q <= 1'b0;
          rd_gnt_q <= 1'b0;
        end
      endcase
    end
  end

  // Beats arriving with nothing outstanding are stale (e.g. after reset) and dropped.
  assign rd_issue   = mux_af.wren && (mux_af.cmd == CMD_READ);
  assign beat_en    = bus.rd_data_valid && (outstanding != '0);
  assign burst_done = beat_en && (beat_cnt == BEAT_W'(BEATS_PER_CMD - 1));
  assign at_max     = (outstanding == 4'(MAX_OUTSTANDING));

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      beat_cnt    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (beat_en) beat_cnt <= burst_done ? '0 : beat_cnt + 1'b1;

      if (rd_issue && !burst_done) begin
        if (!at_max) outstanding <= outstanding + 1'b1;
      end else if (burst_done && !rd_issue) begin
        outstanding <= outstanding - 1'b1;
      end

      if (hold_hit || (rd_issue && !burst_done && at_max)) err_q <= 1'b1;
    end
  end

  assign bus.rd_outstanding = outstanding;
  assign bus.rd_throttle    = at_max | bus.app_af_afull;
  assign bus.timeout_err    = err_q;

`ifdef MIG_ARB_STATS_EN
  logic [15:0] wr_grants, rd_grants, stalls;
  logic        stall_cyc;

  assign stall_cyc = (bus.wr_req | bus.rd_req) &&
                     ((state == IDLE) || (state == TURN) || (state == DRAIN));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_grants <= '0;
      rd_grants <= '0;
      stalls    <= '0;
    end else begin
      if (pick_wr && wr_grants != 16'hFFFF)                 wr_grants <= wr_grants + 1'b1;
      if ((pick_rd || regrant_rd) && rd_grants != 16'hFFFF) rd_grants <= rd_grants + 1'b1;
      if (stall_cyc && stalls != 16'hFFFF)                  stalls    <= stalls + 1'b1;
    end
  end

  assign bus.wr_grant_cnt = wr_grants;
  assign bus.rd_grant_cnt = rd_grants;
  assign bus.stall_cnt    = stalls;
`endif
endmodule
